// File: rtl/locked_adder_pkg.sv
// -----------------------------------------------------------------------------
// locked_adder_pkg
// Shared defaults and helpers for the locked pipelined adder:
//   KEY_W_DEFAULT        default key width in bits
//   CORRECT_KEY_DEFAULT  default unlocking key
//   mask_idx()           selects which key-difference bit masks a given sum bit
// -----------------------------------------------------------------------------
package locked_adder_pkg;

  localparam int KEY_W_DEFAULT = 32;
  localparam logic [31:0] CORRECT_KEY_DEFAULT = 32'h2E77_0869;

  // Sum bit j is masked by difference bit (j mod key_w); keys shorter than the
  // sum simply wrap around.
  function automatic int mask_idx(input int bit_idx, input int key_w);
    return bit_idx % key_w;
  endfunction

endpackage

// File: rtl/locked_pipelined_adder_xnor_rca_chunk.sv
// -----------------------------------------------------------------------------
// xnor_rca_chunk
// Combinational CHUNK-bit ripple-carry adder built around XNOR cells.
// Ports:
//   a_i, b_i  CHUNK-bit operands
//   c_i       carry in
//   s_o       CHUNK-bit sum
//   c_o       carry out of the MSB
// -----------------------------------------------------------------------------
module xnor_rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  logic [CHUNK:0]   carry_s;
  logic [CHUNK-1:0] eq_s;

  // Ripple the carry through the chunk one bit at a time.
  always_comb begin
    carry_s    = {(CHUNK+1){1'b0}};
    s_o        = {CHUNK{1'b0}};
    eq_s       = {CHUNK{1'b0}};
    carry_s[0] = c_i;
    for (int i = 0; i < CHUNK; i++) begin
      // eq is the inverted propagate; xnor-ing it with the carry yields a^b^c.
      eq_s[i]        = a_i[i] ~^ b_i[i];
      s_o[i]         = eq_s[i] ~^ carry_s[i];
      carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & ~eq_s[i]);
    end
    c_o = carry_s[CHUNK];
  end

endmodule

// File: rtl/locked_pipelined_adder.sv
// -----------------------------------------------------------------------------
// locked_pipelined_adder
// Key-locked, chunk-pipelined unsigned adder. S = WIDTH/CHUNK adder stages each
// add one CHUNK-bit slice with the carry registered by the stage before; a
// final output register applies the key mask. Latency is S cycles from the
// accepting edge; a stalled output freezes the whole pipe.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand pair valid       in_ready_o   block accepts operands
//   add1_i       operand A (WIDTH)        add2_i       operand B (WIDTH)
//   key_load_i   capture keyinput_i       keyinput_i   key value (KEY_W)
//   out_valid_o  result valid             out_ready_i  consumer accepts result
//   result_o     {carry, sum}, masked by (key_q ^ CORRECT_KEY)
//   key_ok_o     key_q equals CORRECT_KEY
//
// Build option: define LOCKED_ADDER_STICKY_KEY_EN to let key_q load only once
// per reset; by default every key_load_i pulse reloads key_q.
// -----------------------------------------------------------------------------
module locked_pipelined_adder
  import locked_adder_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               CHUNK       = 4,
  parameter int               KEY_W       = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] CORRECT_KEY = CORRECT_KEY_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             key_load_i,
  input  logic [KEY_W-1:0] keyinput_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             key_ok_o
);

  localparam int S = WIDTH / CHUNK;

  // Per-stage state. Stage k owns sum bits [(k+1)*CHUNK-1:0] and operand bits
  // above that; the remaining bits of these vectors are don't-care and trim
  // away in synthesis.
  logic             v_q   [S];
  logic             v_d   [S];
  logic             c_q   [S];
  logic             c_d   [S];
  logic [WIDTH-1:0] a_q   [S];
  logic [WIDTH-1:0] a_d   [S];
  logic [WIDTH-1:0] b_q   [S];
  logic [WIDTH-1:0] b_d   [S];
  logic [WIDTH-1:0] sum_q [S];
  logic [WIDTH-1:0] sum_d [S];

  // Chunk adder hookup.
  logic [CHUNK-1:0] ca_s [S];
  logic [CHUNK-1:0] cb_s [S];
  logic [CHUNK-1:0] cs_s [S];
  logic             ci_s [S];
  logic             co_s [S];

  logic             stall_s;
  logic             accept_s;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH:0]   result_q;
  logic [WIDTH:0]   result_d;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;
  logic [KEY_W-1:0] diff_s;
  logic [WIDTH-1:0] sum_mask_s;
`ifdef LOCKED_ADDER_STICKY_KEY_EN
  logic             key_used_q;
  logic             key_used_d;
`endif

  // A held result that the consumer refuses freezes every stage.
  assign stall_s     = out_valid_q & ~out_ready_i;
  assign accept_s    = in_valid_i & ~stall_s;
  assign in_ready_o  = ~stall_s;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign key_ok_o    = (key_q == CORRECT_KEY);

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ca_s[k] = add1_i[CHUNK-1:0];
      assign cb_s[k] = add2_i[CHUNK-1:0];
      assign ci_s[k] = 1'b0;
    end else begin : g_rest
      assign ca_s[k] = a_q[k-1][k*CHUNK +: CHUNK];
      assign cb_s[k] = b_q[k-1][k*CHUNK +: CHUNK];
      assign ci_s[k] = c_q[k-1];
    end

    xnor_rca_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i (ca_s[k]),
      .b_i (cb_s[k]),
      .c_i (ci_s[k]),
      .s_o (cs_s[k]),
      .c_o (co_s[k])
    );
  end

  // Stage next-state: advance one stage per cycle unless stalled.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      v_d[k]   = v_q[k];
      c_d[k]   = c_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    if (stall_s) begin
      for (int k = 0; k < S; k++) begin
        v_d[k] = v_q[k];
      end
    end else begin
      v_d[0]              = accept_s;
      a_d[0]              = add1_i;
      b_d[0]              = add2_i;
      sum_d[0]            = {WIDTH{1'b0}};
      sum_d[0][CHUNK-1:0] = cs_s[0];
      c_d[0]              = co_s[0];
      for (int k = 1; k < S; k++) begin
        v_d[k]                        = v_q[k-1];
        a_d[k]                        = a_q[k-1];
        b_d[k]                        = b_q[k-1];
        sum_d[k]                      = sum_q[k-1];
        sum_d[k][k*CHUNK +: CHUNK]    = cs_s[k];
        c_d[k]                        = co_s[k];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < S; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        v_q[k]   <= v_d[k];
        c_q[k]   <= c_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Key difference and the per-sum-bit mask derived from it.
  always_comb begin
    diff_s     = key_q ^ CORRECT_KEY;
    sum_mask_s = {WIDTH{1'b0}};
    for (int j = 0; j < WIDTH; j++) begin
      sum_mask_s[j] = diff_s[mask_idx(j, KEY_W)];
    end
  end

  // Output register next-state; the mask uses the key held in the load cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (stall_s) begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
    end else begin
      out_valid_d = v_q[S-1];
      if (v_q[S-1]) begin
        result_d = {c_q[S-1] ^ (|diff_s), sum_q[S-1] ^ sum_mask_s};
      end else begin
        result_d = result_q;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      result_q    <= {(WIDTH+1){1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // Key next-state; the sticky build honours only the first load after reset.
  always_comb begin
    key_d = key_q;
`ifdef LOCKED_ADDER_STICKY_KEY_EN
    key_used_d = key_used_q;
    if (key_load_i && !key_used_q) begin
      key_d      = keyinput_i;
      key_used_d = 1'b1;
    end else begin
      key_d      = key_q;
      key_used_d = key_used_q;
    end
`else
    if (key_load_i) begin
      key_d = keyinput_i;
    end else begin
      key_d = key_q;
    end
`endif
  end

  // Key registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= {KEY_W{1'b0}};
`ifdef LOCKED_ADDER_STICKY_KEY_EN
      key_used_q <= 1'b0;
`endif
    end else begin
      key_q <= key_d;
`ifdef LOCKED_ADDER_STICKY_KEY_EN
      key_used_q <= key_used_d;
`endif
    end
  end

endmodule

// File: tb/tb_locked_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_locked_pipelined_adder
// Directed vectors with hand-computed results, plus a transaction-level model
// (queue of accepted operands aged in un-stalled cycles, key applied when an
// operation reaches the output) checked against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_locked_pipelined_adder;

  localparam int          S      = 4;
  localparam logic [31:0] KEY_OK = 32'h2E77_0869;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] add1      = 16'h0000;
  logic [15:0] add2      = 16'h0000;
  logic        key_load  = 1'b0;
  logic [31:0] keyin     = 32'h0000_0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] result;
  logic        key_ok;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  locked_pipelined_adder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .key_load_i  (key_load),
    .keyinput_i  (keyin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .key_ok_o    (key_ok)
  );

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Locked sum straight from the rules: true sum, low bits xor key difference,
  // carry xor "any difference".
  function automatic logic [16:0] locked_sum(input logic [15:0] a, input logic [15:0] b,
                                             input logic [31:0] key);
    logic [16:0] s;
    logic [31:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = key ^ KEY_OK;
    for (int j = 0; j < 16; j++) s[j] = s[j] ^ d[j % 32];
    s[16] = s[16] ^ (|d);
    return s;
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          age;
  } op_t;

  op_t         fl[$];
  logic        m_valid    = 1'b0;
  logic [16:0] m_result   = 17'h0_0000;
  logic [31:0] m_key      = 32'h0000_0000;
  logic        m_key_used = 1'b0;
  logic [16:0] got_q[$];

  initial begin
    op_t o;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fl.delete();
        m_valid    = 1'b0;
        m_result   = 17'h0_0000;
        m_key      = 32'h0000_0000;
        m_key_used = 1'b0;
      end else begin
        if (!(m_valid && !out_ready)) begin
          m_valid = 1'b0;
          if (fl.size() > 0 && fl[0].age == S) begin
            o        = fl.pop_front();
            m_result = locked_sum(o.a, o.b, m_key);
            m_valid  = 1'b1;
          end
          foreach (fl[i]) fl[i].age = fl[i].age + 1;
          if (in_valid) begin
            o.a   = add1;
            o.b   = add2;
            o.age = 1;
            fl.push_back(o);
          end
        end
`ifdef LOCKED_ADDER_STICKY_KEY_EN
        if (key_load && !m_key_used) begin
          m_key      = keyin;
          m_key_used = 1'b1;
        end
`else
        if (key_load) m_key = keyin;
`endif
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check_bit("cyc out_valid", out_valid, m_valid);
      check_bit("cyc in_ready", in_ready, !(m_valid && !out_ready));
      check_bit("cyc key_ok", key_ok, m_key == KEY_OK);
      if (m_valid || !rst_n) check_val("cyc result", {15'd0, result}, {15'd0, m_result});
      if (out_valid && out_ready && rst_n) got_q.push_back(result);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input string name);
    int n;
    add1     = a;
    add2     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (n < 12 && !out_valid) begin
      step();
      n++;
    end
    check_val({name, " latency"}, n, 4);
    check_val({name, " result"}, {15'd0, result}, exp);
    step();
  endtask

  logic [15:0] ba[5]    = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD};
  logic [15:0] bb[5]    = '{16'h4321, 16'hFFFF, 16'h8000, 16'hF0F0, 16'h1111};
  logic [31:0] bexp[6]  = '{32'h0_5555, 32'h1_FFFE, 32'h1_0000, 32'h0_FFFF, 32'h0_BCDE,
                            32'h0_0003};

  initial begin
    int cnt;
    // Reset state.
    repeat (3) step();
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset key_ok", key_ok, 1'b0);
    check_val("reset result", {15'd0, result}, 32'h0);
    rst_n = 1'b1;

    // No key loaded: key_q = 0, first edge after release accepts.
    do_op(16'h5555, 16'hAAAA, 32'h1_F796, "nokey 5555+AAAA");
    check_bit("nokey key_ok", key_ok, 1'b0);

    // Correct key.
    keyin    = KEY_OK;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    check_bit("load key_ok", key_ok, 1'b1);
    do_op(16'h29AF, 16'h7A1B, 32'h0_A3CA, "key 29AF+7A1B");
    do_op(16'h8943, 16'hFFFF, 32'h1_8942, "key 8943+FFFF");
    do_op(16'hFFFF, 16'h0001, 32'h1_0000, "key FFFF+0001");
    do_op(16'h0000, 16'h0000, 32'h0_0000, "key 0000+0000");

    // Back-to-back burst with a 3-cycle stall; a sixth operand waits it out.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      add1     = ba[i];
      add2     = bb[i];
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b0;
    add1      = 16'h0001;
    add2      = 16'h0002;
    #1;
    check_bit("stall in_ready", in_ready, 1'b0);
    repeat (3) step();
    out_ready = 1'b1;
    #1;
    check_bit("unstall in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check_val("burst count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check_val("burst order", {15'd0, got_q[i]}, bexp[i]);
    end

    // Reset with operations in flight and a result held at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      add1     = 16'h0100;
      add2     = 16'h0010;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check_bit("pre-reset out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midreset out_valid", out_valid, 1'b0);
    check_bit("midreset key_ok", key_ok, 1'b0);
    check_bit("midreset in_ready", in_ready, 1'b1);
    step();
    step();
    out_ready = 1'b1;
    rst_n     = 1'b1;
    cnt = 0;
    repeat (10) begin
      step();
      if (out_valid) cnt++;
    end
    check_val("no stale result", cnt, 0);

    // Key reload: sticky build ignores the second load.
    keyin    = KEY_OK;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    check_bit("reload1 key_ok", key_ok, 1'b1);
    keyin    = 32'h0000_0000;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
`ifdef LOCKED_ADDER_STICKY_KEY_EN
    check_bit("reload2 key_ok", key_ok, 1'b1);
    do_op(16'h29AF, 16'h7A1B, 32'h0_A3CA, "reload 29AF+7A1B");
`else
    check_bit("reload2 key_ok", key_ok, 1'b0);
    do_op(16'h29AF, 16'h7A1B, 32'h1_ABA3, "reload 29AF+7A1B");
`endif

    // Key loaded while an operation is in flight: it sees the new key.
    got_q.delete();
    add1     = 16'h0001;
    add2     = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    keyin    = KEY_OK;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    repeat (8) step();
    check_val("inflight count", got_q.size(), 1);
    if (got_q.size() > 0) check_val("inflight result", {15'd0, got_q[0]}, 32'h0_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/locked_pipelined_adder.md
LOCKED_PIPELINED_ADDER -- requirements
Module: locked_pipelined_adder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WIDTH, 16, operand width in bits.
- CHUNK, 4, bits per pipeline stage; WIDTH SHALL be a multiple of CHUNK.
- KEY_W, 32, key width in bits.
- CORRECT_KEY, 32'h2E770869, unlocking key.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block accepts operands.
- add1_i  input  WIDTH  operand A.
- add2_i  input  WIDTH  operand B.
- key_load_i  input  1  capture keyinput_i this cycle.
- keyinput_i  input  KEY_W  key value.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH+1  {carry, sum}, possibly key-corrupted.
- key_ok_o  output  1  stored key equals CORRECT_KEY.
REQ-003 One clock (clk_i) SHALL be used; reset (rst_ni) SHALL be asynchronous and active-low.

Function
REQ-004 The pipeline SHALL have S = WIDTH/CHUNK stages; stage k adds bits [k*CHUNK +: CHUNK] with the registered carry from stage k-1; stage 0 carry-in SHALL be 0.
REQ-005 Upper operand chunks and lower sum chunks SHALL travel with their stage, each stage holding its own valid bit.
REQ-006 Latency SHALL be exactly S cycles from the accepting edge (in_valid_i && in_ready_o) to out_valid_o high, with no stall in between.
REQ-007 Throughput SHALL be one operation per cycle with no stall.
REQ-008 Stall = out_valid_o && !out_ready_i; on stall every stage SHALL hold its contents, and in_ready_o SHALL equal !stall, combinationally.
REQ-009 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated; result_o SHALL stay stable while stalled.
REQ-010 The lock is defined as follows:
- diff = key_q ^ CORRECT_KEY.
- Sum bit j SHALL be XORed with diff[j mod KEY_W].
- result_o[WIDTH] SHALL be the carry XORed with the OR-reduction of diff.
- The mask SHALL be applied at the final-stage register load, using the key_q held in that cycle.
REQ-011 key_load_i high SHALL load keyinput_i into key_q on the next edge; new operations and in-flight operations not yet in the final register SHALL see the new key.
REQ-012 key_ok_o SHALL equal (key_q == CORRECT_KEY), decoded combinationally from key_q.
REQ-013 Operand addition SHALL be unsigned modulo 2^(WIDTH+1); carry out of the MSB chunk SHALL be result_o[WIDTH].

Reset
REQ-014 While rst_ni is low, the block SHALL hold:
- all stage valids, out_valid_o, key_q and result_o at 0;
- in_ready_o at 1;
- key_ok_o at 0, unless CORRECT_KEY is 0.
REQ-015 Reset asserted mid-operation SHALL discard all in-flight operations immediately; no partial result SHALL appear after release.
REQ-016 The first acceptance SHALL be possible on the first rising edge after rst_ni deasserts.

Configuration
REQ-017 Macro LOCKED_ADDER_STICKY_KEY_EN SHALL control key loading:
- Defined: key_q loads at most once per reset; later key_load_i pulses are ignored.
- Undefined: every key_load_i pulse reloads key_q.

Structure
REQ-018 Package locked_adder_pkg SHALL hold the KEY_W default, the CORRECT_KEY default and the mask-bit selection function.
REQ-019 Combinational sub-module xnor_rca_chunk SHALL implement one CHUNK-bit XNOR-based ripple adder with carry-in and carry-out; the top SHALL instantiate S copies.

Verification (WIDTH=16, CHUNK=4, S=4)
REQ-020 Correct key: load 2E770869, then 29AF+7A1B -> result_o=17'h0A3CA exactly 4 cycles after acceptance; key_ok_o=1.
REQ-021 Correct key, 8943+FFFF -> 17'h18942.
REQ-022 No key after reset (key_q=0), 5555+AAAA -> 17'h1F796; key_ok_o=0.
REQ-023 Backpressure: five back-to-back inputs with out_ready_i low for 3 cycles -> all five results in order, values unchanged while stalled, in_ready_o low exactly while stalled.
REQ-024 rst_ni low with 3 operations in flight -> out_valid_o=0 at once, key_ok_o=0, no stale result after release.
REQ-025 With LOCKED_ADDER_STICKY_KEY_EN: load 2E770869, then load 0 -> key_ok_o stays 1. Without the macro: same sequence -> key_ok_o=0.
